rom_access_arbiter: RTL and testbench
=====================================

// Module: rom_access_arbiter
// PURPOSE
//  Shares the single instruction ROM between two requesters: instruction fetch (port F)
//  and a data/debug read port (port D). Round-robin arbitration, one outstanding access
//  at a time, valid/ready handshakes on request and response. Converts byte addresses
//  to ROM word indices and flags misaligned/out-of-range reads. Sits between fetch stage,
//  load path and the combinational ROM.
// PARAMETERS
//  ROM_DEPTH  64            number of 32-bit words in the ROM (word index 0..ROM_DEPTH-1)
//  ERR_DATA   32'h00000013  data returned with rsp_err=1 (NOP encoding)
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   synchronous, active-high reset
//  f_req_valid      in   1   fetch request valid
//  f_req_ready      out  1   fetch request accepted this cycle
//  f_req_addr       in   32  fetch byte address
//  f_flush          in   1   fetch redirect: cancel pending/in-flight fetch
//  f_rsp_valid      out  1   fetch response valid
//  f_rsp_ready      in   1   fetch consumer ready
//  f_rsp_data       out  32  fetched instruction word
//  f_rsp_err        out  1   misaligned or out-of-range fetch
//  d_req_valid / d_req_ready / d_req_addr   same as F, data port (no flush)
//  d_rsp_valid / d_rsp_ready / d_rsp_data / d_rsp_err   same as F, data port
//  rom_address      out  32  word index to ROM (zero-extended)
//  rom_instruction  in   32  ROM combinational read data
//  busy             out  1   1 whenever state != IDLE
// BEHAVIOUR
//  States: IDLE -> READ -> RESP -> IDLE. owner (0=F,1=D), last_grant, addr_q, data_q, err_q.
//  Reset (sync, rst=1 at edge): state=IDLE, last_grant=1 (F wins first tie), all *_req_ready,
//   *_rsp_valid, *_rsp_err, busy = 0; *_rsp_data, rom_address = 0. Reset in READ/RESP
//   drops the access; no response is ever delivered for it.
//  IDLE: eligible F = f_req_valid & ~f_flush; eligible D = d_req_valid.
//   One eligible -> grant it; both -> grant port != last_grant. req_ready is combinational,
//   asserted only for the winner, only in IDLE. On grant: owner, last_grant <= winner;
//   addr_q <= req_addr[31:2]; err_q <= (req_addr[1:0]!=0) | (req_addr[31:2] >= ROM_DEPTH);
//   -> READ. No eligible request: stay IDLE.
//  READ: rom_address = addr_q (held from grant+1 cycle; 0 otherwise). At edge: data_q <=
//   err_q ? ERR_DATA : rom_instruction; -> RESP.
//  RESP: owner's rsp_valid=1, rsp_data=data_q, rsp_err=err_q; held stable until rsp_ready.
//   Edge with rsp_ready=1 -> IDLE. Non-owner rsp_valid=0.
//  Latency: accept at edge N -> rsp_valid high from cycle N+2. Max throughput 1 per 3 cycles.
//  Flush: f_flush=1 while owner=F in READ or RESP -> response suppressed (f_rsp_valid=0 that
//   cycle), -> IDLE next edge. Flush has no effect on D-owned accesses. In IDLE, flush masks
//   F that cycle, so a simultaneous D request wins regardless of last_grant.
//  Simultaneous f_rsp_ready and f_flush in RESP: flush wins (treated as cancelled, not consumed).
//  Requests arriving while busy: req_ready=0; requester must hold valid and addr stable.
//  Word index compare is unsigned on full 30 bits; addresses >= 4*ROM_DEPTH are errors.
// TESTING
//  1 Reset, F req addr 0x08 -> f_req_ready in IDLE, f_rsp_valid at N+2, data=ROM[2], err=0.
//  2 F and D valid together from reset -> F granted first; both held -> D next, then F (alternate).
//  3 D req addr 0x06 -> d_rsp_err=1, d_rsp_data=0x00000013; addr 4*ROM_DEPTH -> err=1 also.
//  4 F req, f_rsp_ready=0 for 5 cycles -> f_rsp_valid/data stable, busy=1; D waits (ready=0).
//  5 F req then f_flush in READ -> no f_rsp_valid, IDLE next; pending D granted immediately after.
//  6 rst pulsed in RESP -> all outputs 0 next cycle, no response, next F tie-win restored.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one combinational instruction ROM between the fetch
// port (F) and the data/debug port (D), one outstanding access at a time.
module rom_access_arbiter #(
    parameter int          ROM_DEPTH = 64,
    parameter logic [31:0] ERR_DATA  = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    // Fetch port
    input  logic        f_req_valid,
    output logic        f_req_ready,
    input  logic [31:0] f_req_addr,
    input  logic        f_flush,
    output logic        f_rsp_valid,
    input  logic        f_rsp_ready,
    output logic [31:0] f_rsp_data,
    output logic        f_rsp_err,
    // Data/debug port
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    // ROM side
    output logic [31:0] rom_address,
    input  logic [31:0] rom_instruction,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_RESP
    } state_t;

    localparam logic [29:0] DEPTH_WORDS = 30'(ROM_DEPTH);

    state_t      r_state;
    state_t      w_nextState;
    logic        r_owner;
    logic        r_lastGrant;
    logic [29:0] r_addr;
    logic [31:0] r_data;
    logic        r_err;

    logic        w_eligF;
    logic        w_eligD;
    logic        w_grant;
    logic        w_winner;
    logic [31:0] w_reqAddr;
    logic        w_reqErr;
    logic        w_flushOwned;
    logic        w_rspF;
    logic        w_rspD;
    logic        w_ownerRspReady;

    // A flush hides the fetch request, so a concurrent D request wins outright.
    assign w_eligF = f_req_valid & ~f_flush;
    assign w_eligD = d_req_valid;
    assign w_grant = (r_state == S_IDLE) & (w_eligF | w_eligD);

    always_comb begin
        w_winner = 1'b0;
        if (w_eligF && w_eligD) begin
            w_winner = ~r_lastGrant;
        end else if (w_eligD) begin
            w_winner = 1'b1;
        end
    end

    assign w_reqAddr = w_winner ? d_req_addr : f_req_addr;
    assign w_reqErr  = (w_reqAddr[1:0] != 2'b00) | (w_reqAddr[31:2] >= DEPTH_WORDS);

    assign w_flushOwned    = f_flush & ~r_owner;
    assign w_ownerRspReady = r_owner ? d_rsp_ready : f_rsp_ready;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_nextState = S_READ;
                end
            end
            S_READ: begin
                w_nextState = w_flushOwned ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                // A flush cancels even when the consumer is ready in the same cycle.
                if (w_flushOwned || w_ownerRspReady) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_addr      <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_grant) begin
                r_owner     <= w_winner;
                r_lastGrant <= w_winner;
                r_addr      <= w_reqAddr[31:2];
                r_err       <= w_reqErr;
            end
            if (r_state == S_READ) begin
                r_data <= r_err ? ERR_DATA : rom_instruction;
            end
        end
    end

    assign f_req_ready = w_grant & ~w_winner;
    assign d_req_ready = w_grant & w_winner;

    assign w_rspF = (r_state == S_RESP) & ~r_owner & ~f_flush;
    assign w_rspD = (r_state == S_RESP) & r_owner;

    assign f_rsp_valid = w_rspF;
    assign f_rsp_data  = w_rspF ? r_data : 32'h0;
    assign f_rsp_err   = w_rspF & r_err;
    assign d_rsp_valid = w_rspD;
    assign d_rsp_data  = w_rspD ? r_data : 32'h0;
    assign d_rsp_err   = w_rspD & r_err;

    assign rom_address = (r_state == S_READ) ? {2'b00, r_addr} : 32'h0;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: table of single accesses plus hand-written
// sequences for ties, back-pressure, flush and reset, scored through a queue.
module tb_rom_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req_valid, f_req_ready, f_flush, f_rsp_valid, f_rsp_ready, f_rsp_err;
    logic [31:0] f_req_addr, f_rsp_data;
    logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_req_addr, d_rsp_data;
    logic [31:0] rom_address, rom_instruction;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        expErr;
        logic [31:0] expData;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[8];

    rom_access_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
        .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready),
        .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .rom_address(rom_address), .rom_instruction(rom_instruction), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: every word has a distinct pattern derived from its index.
    function automatic logic [31:0] romWord(input logic [31:0] idx);
        return {8'hA5, idx[7:0], ~idx[7:0], 8'h3C};
    endfunction

    assign rom_instruction = romWord(rom_address);

    function automatic exp_t expectFor(input logic port, input logic [31:0] addr);
        exp_t e;
        e.port = port;
        e.err  = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd64);
        e.data = e.err ? 32'h00000013 : romWord({2'b00, addr[31:2]});
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        f_req_valid = 1'b0; f_req_addr = '0; f_flush = 1'b0; f_rsp_ready = 1'b1;
        d_req_valid = 1'b0; d_req_addr = '0; d_rsp_ready = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_handshakes"},
                    {28'h0, f_req_ready, d_req_ready, f_rsp_valid, d_rsp_valid}, 32'h0);
        checkOutput({tag, "_errs"}, {30'h0, f_rsp_err, d_rsp_err}, 32'h0);
        checkOutput({tag, "_data"}, f_rsp_data | d_rsp_data, 32'h0);
        checkOutput({tag, "_rom_address"}, rom_address, 32'h0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
    endtask

    // One full access: grant, READ-phase address, N+2 response, consumption.
    task automatic applyStimulus(input logic expPort, input logic holdReq, input exp_t e);
        int          cyc;
        logic        gotPort;
        logic [31:0] addr;
        exp_t        got;
        #1;
        cyc = 0;
        while (!(f_req_ready || d_req_ready) && cyc < 8) begin
            nextCycle();
            cyc++;
        end
        checkOutput("grant_seen", f_req_ready | d_req_ready, 1'b1);
        if (!(f_req_ready || d_req_ready)) return;
        gotPort = d_req_ready;
        checkOutput("winner", gotPort, expPort);
        addr = gotPort ? d_req_addr : f_req_addr;
        sbQ.push_back(e);
        nextCycle();
        if (!holdReq) begin
            if (gotPort) d_req_valid = 1'b0;
            else         f_req_valid = 1'b0;
        end
        checkOutput("rom_address", rom_address, {2'b00, addr[31:2]});
        cyc = 1;
        while (!(f_rsp_valid || d_rsp_valid) && cyc < 8) begin
            nextCycle();
            cyc++;
        end
        checkOutput("rsp_latency", cyc, 2);
        if (f_rsp_valid || d_rsp_valid) begin
            got = sbQ.pop_front();
            checkOutput("rsp_port", d_rsp_valid, got.port);
            checkOutput("rsp_data", got.port ? d_rsp_data : f_rsp_data, got.data);
            checkOutput("rsp_err", got.port ? d_rsp_err : f_rsp_err, got.err);
        end
        nextCycle();
        checkOutput("busy_after", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        vecs[0] = '{1'b0, 32'h00000008, 1'b0, romWord(32'd2)};
        vecs[1] = '{1'b1, 32'h00000006, 1'b1, 32'h00000013};
        vecs[2] = '{1'b1, 32'h00000100, 1'b1, 32'h00000013};
        vecs[3] = '{1'b1, 32'h000000FC, 1'b0, romWord(32'd63)};
        vecs[4] = '{1'b0, 32'h00000002, 1'b1, 32'h00000013};
        vecs[5] = '{1'b0, 32'hFFFFFFFC, 1'b1, 32'h00000013};
        vecs[6] = '{1'b1, 32'h00000000, 1'b0, romWord(32'd0)};
        vecs[7] = '{1'b0, 32'h000000FC, 1'b0, romWord(32'd63)};

        applyReset();
        checkQuiet("reset");

        for (int i = 0; i < 8; i++) begin
            e.port = vecs[i].port;
            e.data = vecs[i].expData;
            e.err  = vecs[i].expErr;
            if (vecs[i].port) begin
                d_req_valid = 1'b1; d_req_addr = vecs[i].addr;
            end else begin
                f_req_valid = 1'b1; f_req_addr = vecs[i].addr;
            end
            applyStimulus(vecs[i].port, 1'b0, e);
        end

        // Tie from reset: F first, then strict alternation while both are held.
        applyReset();
        f_req_valid = 1'b1; f_req_addr = 32'h10;
        d_req_valid = 1'b1; d_req_addr = 32'h20;
        applyStimulus(1'b0, 1'b1, expectFor(1'b0, 32'h10));
        applyStimulus(1'b1, 1'b1, expectFor(1'b1, 32'h20));
        applyStimulus(1'b0, 1'b1, expectFor(1'b0, 32'h10));
        applyStimulus(1'b1, 1'b1, expectFor(1'b1, 32'h20));
        f_req_valid = 1'b0; d_req_valid = 1'b0;

        // Back-pressure on F: response held stable, D kept waiting.
        f_rsp_ready = 1'b0;
        f_req_valid = 1'b1; f_req_addr = 32'h14;
        #1;
        checkOutput("bp_f_ready", f_req_ready, 1'b1);
        sbQ.push_back(expectFor(1'b0, 32'h14));
        nextCycle();
        f_req_valid = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 32'h18;
        nextCycle();
        e = sbQ.pop_front();
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_rsp_valid", f_rsp_valid, 1'b1);
            checkOutput("bp_rsp_data", f_rsp_data, e.data);
            checkOutput("bp_busy", busy, 1'b1);
            checkOutput("bp_d_ready", d_req_ready, 1'b0);
            nextCycle();
        end
        f_rsp_ready = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 1'b0, expectFor(1'b1, 32'h18));

        // Flush during READ: F dropped, waiting D granted straight away.
        f_req_valid = 1'b1; f_req_addr = 32'h1C;
        #1;
        checkOutput("fl_f_ready", f_req_ready, 1'b1);
        sbQ.push_back(expectFor(1'b0, 32'h1C));
        nextCycle();
        f_req_valid = 1'b0; f_flush = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 32'h24;
        #1;
        checkOutput("fl_read_busy", busy, 1'b1);
        nextCycle();
        f_flush = 1'b0;
        #1;
        checkOutput("fl_idle_busy", busy, 1'b0);
        checkOutput("fl_no_f_rsp", f_rsp_valid, 1'b0);
        checkOutput("fl_d_ready", d_req_ready, 1'b1);
        void'(sbQ.pop_front());
        applyStimulus(1'b1, 1'b0, expectFor(1'b1, 32'h24));

        // Last grant was D, yet a flushed F tie still loses to D.
        f_req_valid = 1'b1; f_req_addr = 32'h04; f_flush = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 32'h08;
        #1;
        checkOutput("mask_f_ready", f_req_ready, 1'b0);
        applyStimulus(1'b1, 1'b0, expectFor(1'b1, 32'h08));
        f_flush = 1'b0; f_req_valid = 1'b0;

        // Flush together with rsp_ready in RESP: cancelled, not delivered.
        f_rsp_ready = 1'b0;
        f_req_valid = 1'b1; f_req_addr = 32'h20;
        #1;
        checkOutput("flr_f_ready", f_req_ready, 1'b1);
        sbQ.push_back(expectFor(1'b0, 32'h20));
        nextCycle();
        f_req_valid = 1'b0;
        nextCycle();
        checkOutput("flr_rsp_valid", f_rsp_valid, 1'b1);
        f_flush = 1'b1; f_rsp_ready = 1'b1;
        #1;
        checkOutput("flr_suppressed", f_rsp_valid, 1'b0);
        checkOutput("flr_data_zero", f_rsp_data, 32'h0);
        nextCycle();
        f_flush = 1'b0;
        #1;
        checkOutput("flr_idle", busy, 1'b0);
        checkOutput("flr_no_rsp", f_rsp_valid, 1'b0);
        void'(sbQ.pop_front());

        // Reset while in RESP drops the access and restores F tie priority.
        f_rsp_ready = 1'b0;
        f_req_valid = 1'b1; f_req_addr = 32'h28;
        #1;
        sbQ.push_back(expectFor(1'b0, 32'h28));
        nextCycle();
        f_req_valid = 1'b0;
        nextCycle();
        checkOutput("rr_rsp_valid", f_rsp_valid, 1'b1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        f_rsp_ready = 1'b1;
        #1;
        checkQuiet("rst_resp");
        void'(sbQ.pop_front());
        nextCycle();
        checkOutput("rr_no_late_rsp", f_rsp_valid | d_rsp_valid, 1'b0);
        f_req_valid = 1'b1; f_req_addr = 32'h30;
        d_req_valid = 1'b1; d_req_addr = 32'h34;
        applyStimulus(1'b0, 1'b0, expectFor(1'b0, 32'h30));
        applyStimulus(1'b1, 1'b0, expectFor(1'b1, 32'h34));

        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
